// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the pipelined core's extension unit.
//   ext_mode_t  : operation select for ext_datapath / ext_pipe_unit
//   UPPER_SHIFT : bit position the immediate lands at in UPPER mode
// ---------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [2:0] {
        EXT_ZERO   = 3'd0,  // zero-extended immediate
        EXT_SIGN   = 3'd1,  // sign-extended immediate
        EXT_UPPER  = 3'd2,  // {imm, 16'b0}, sign-extended from bit 31
        EXT_BRANCH = 3'd3,  // sign-extended immediate << BR_SHIFT
        EXT_LB     = 3'd4,  // signed byte load
        EXT_LBU    = 3'd5,  // unsigned byte load
        EXT_LH     = 3'd6,  // signed half load
        EXT_LHU    = 3'd7   // unsigned half load
    } ext_mode_t;

    localparam int UPPER_SHIFT = 16;

endpackage

// File: rtl/ext_datapath.sv
// ---------------------------------------------------------------------------
// ext_datapath
// Purely combinational immediate extension and load-lane extraction.
//   ExtMode  : operation select (ext_mode_t encoding)
//   ByteAddr : little-endian byte offset, used by the load modes only
//   ExtIn    : raw immediate (low IMM_W bits) or loaded word
//   Result   : extended value
//   Misalign : half access with ByteAddr[0]=1
// ---------------------------------------------------------------------------
module ext_datapath
    import core_pkg::*;
#(
    parameter  int IMM_W    = 16,
    parameter  int DATA_W   = 32,
    parameter  int BR_SHIFT = 2,
    localparam int LANE_W   = $clog2(DATA_W / 8)
) (
    input  logic [2:0]        ExtMode,
    input  logic [LANE_W-1:0] ByteAddr,
    input  logic [DATA_W-1:0] ExtIn,
    output logic [DATA_W-1:0] Result,
    output logic              Misalign
);

    ext_mode_t          mode;
    logic [IMM_W-1:0]   imm;
    logic [DATA_W-1:0]  immZero;
    logic [DATA_W-1:0]  immSign;
    logic [31:0]        upper32;
    logic [7:0]         byteVal;
    logic [15:0]        halfVal;
    logic               isHalf;

    assign mode    = ext_mode_t'(ExtMode);
    assign imm     = ExtIn[IMM_W-1:0];
    assign immZero = DATA_W'(imm);
    assign immSign = DATA_W'($signed(imm));

    // UPPER always forms a 32-bit value first, then widens from bit 31 so a
    // 64-bit datapath sees the same result as the 32-bit core.
    assign upper32 = 32'(immZero << UPPER_SHIFT);

    // Byte k sits at bits [8k+7:8k]; a half ignores ByteAddr[0], so an odd
    // half address reads the aligned half containing it.
    assign byteVal = ExtIn[{ByteAddr, 3'b000} +: 8];
    assign halfVal = ExtIn[{ByteAddr[LANE_W-1:1], 4'b0000} +: 16];

    assign isHalf   = (mode == EXT_LH) || (mode == EXT_LHU);
    assign Misalign = isHalf && ByteAddr[0];

    // NOTE: Result gets a value on every path through the case, so no latch
    // is inferred even if an encoding is ever left unlisted.
    always_comb begin
        Result = '0;
        case (mode)
            EXT_ZERO:   Result = immZero;
            EXT_SIGN:   Result = immSign;
            EXT_UPPER:  Result = DATA_W'($signed(upper32));
            EXT_BRANCH: Result = immSign << BR_SHIFT;
            EXT_LB:     Result = DATA_W'($signed(byteVal));
            EXT_LBU:    Result = DATA_W'(byteVal);
            EXT_LH:     Result = DATA_W'($signed(halfVal));
            EXT_LHU:    Result = DATA_W'(halfVal);
            default:    Result = '0;
        endcase
    end

endmodule

// File: rtl/ext_pipe_unit.sv
// ---------------------------------------------------------------------------
// ext_pipe_unit
// Registered extension stage with a two-entry valid/ready elastic buffer.
//   CLK, Reset         : rising-edge clock, synchronous active-high reset
//   InValid / InReady  : upstream handshake (InReady is a pure register)
//   ExtMode, ByteAddr,
//   ExtIn              : request payload, see ext_datapath
//   OutValid / OutReady: downstream handshake
//   ExtOut, Misalign   : result and misaligned-half flag, travel together
// ---------------------------------------------------------------------------
module ext_pipe_unit
    import core_pkg::*;
#(
    parameter  int IMM_W    = 16,
    parameter  int DATA_W   = 32,
    parameter  int BR_SHIFT = 2,
    localparam int LANE_W   = $clog2(DATA_W / 8)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [2:0]        ExtMode,
    input  logic [LANE_W-1:0] ByteAddr,
    input  logic [DATA_W-1:0] ExtIn,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] ExtOut,
    output logic              Misalign
);

    logic [DATA_W-1:0] newData;
    logic              newMis;

    logic              mainValid, mainValidNx;
    logic [DATA_W-1:0] mainData,  mainDataNx;
    logic              mainMis,   mainMisNx;
    logic              skidValid, skidValidNx;
    logic [DATA_W-1:0] skidData,  skidDataNx;
    logic              skidMis,   skidMisNx;
    logic              inReadyReg;

    logic              accept;
    logic              drain;

    ext_datapath #(
        .IMM_W    (IMM_W),
        .DATA_W   (DATA_W),
        .BR_SHIFT (BR_SHIFT)
    ) uDatapath (
        .ExtMode  (ExtMode),
        .ByteAddr (ByteAddr),
        .ExtIn    (ExtIn),
        .Result   (newData),
        .Misalign (newMis)
    );

    assign accept = InValid && inReadyReg;
    assign drain  = mainValid && OutReady;

    // The skid entry only fills when main is stalled, and InReady is low
    // whenever it is full, so accept and a full skid never coincide.
    always_comb begin
        mainValidNx = mainValid;
        mainDataNx  = mainData;
        mainMisNx   = mainMis;
        skidValidNx = skidValid;
        skidDataNx  = skidData;
        skidMisNx   = skidMis;

        if (drain) begin
            if (skidValid) begin
                mainDataNx  = skidData;
                mainMisNx   = skidMis;
                skidValidNx = 1'b0;
            end else if (accept) begin
                mainDataNx  = newData;
                mainMisNx   = newMis;
            end else begin
                mainValidNx = 1'b0;
            end
        end else if (accept) begin
            if (!mainValid) begin
                mainValidNx = 1'b1;
                mainDataNx  = newData;
                mainMisNx   = newMis;
            end else begin
                skidValidNx = 1'b1;
                skidDataNx  = newData;
                skidMisNx   = newMis;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            // NOTE: the payload registers are reset along with the valid
            // bits so ExtOut/Misalign read zero and no stale data survives.
            mainValid  <= 1'b0;
            mainData   <= '0;
            mainMis    <= 1'b0;
            skidValid  <= 1'b0;
            skidData   <= '0;
            skidMis    <= 1'b0;
            inReadyReg <= 1'b0;
        end else begin
            mainValid  <= mainValidNx;
            mainData   <= mainDataNx;
            mainMis    <= mainMisNx;
            skidValid  <= skidValidNx;
            skidData   <= skidDataNx;
            skidMis    <= skidMisNx;
            // Registered copy of !skidValid: keeps OutReady out of the
            // upstream ready path.
            inReadyReg <= !skidValidNx;
        end
    end

    assign InReady  = inReadyReg;
    assign OutValid = mainValid;
    assign ExtOut   = mainData;
    assign Misalign = mainMis;

endmodule

// File: doc/ext_pipe_unit.md
Name: ext_pipe_unit

Overview:
- Parametrised, registered successor to the single-cycle immediate extender.
- Handles immediate extension (zero, sign, upper, branch-offset) and load-data lane extraction/extension (byte/half, signed/unsigned) in one pipeline stage.
- Uses a valid/ready elastic (skid) buffer so it can sit between the decode/memory stage and writeback in the pipelined core without combinational ready paths.

Parameters:
- IMM_W, 16, width of the immediate field taken from ExtIn[IMM_W-1:0].
- DATA_W, 32, width of data in and out. Legal values: 32 or 64.
- BR_SHIFT, 2, left shift applied in branch-offset mode.
- LANE_W, $clog2(DATA_W/8), derived localparam. It is the width of ByteAddr.

Ports:
- CLK: in, 1, clock, rising edge.
- Reset: in, 1, synchronous, active-high reset.
- InValid: in, 1, upstream has a request.
- InReady: out, 1, unit can accept a request this cycle.
- ExtMode: in, 3, operation select (see Behaviour).
- ByteAddr: in, LANE_W, byte offset for load modes.
- ExtIn: in, DATA_W, raw immediate (low bits) or loaded word.
- OutValid: out, 1, ExtOut is valid.
- OutReady: in, 1, downstream accepts.
- ExtOut: out, DATA_W, extended result.
- Misalign: out, 1, result came from a misaligned half access; travels with ExtOut.

Behaviour:
- Modes:
  - 0 ZERO: ExtOut = zero-extended imm.
  - 1 SIGN: ExtOut = sign-extended imm.
  - 2 UPPER: {imm, 16'b0}, then sign-extended from bit 31 to DATA_W.
  - 3 BRANCH: sign-extended imm << BR_SHIFT; bits shifted out are lost.
  - 4 LB: signed byte. 5 LBU: unsigned byte.
  - 6 LH: signed half. 7 LHU: unsigned half.
- Byte lanes are little-endian: byte k = ExtIn[8k+7:8k], k = ByteAddr. Half h = ByteAddr>>1.
- Half modes with ByteAddr[0]=1:
  - Result uses lane ByteAddr with bit 0 cleared.
  - Misalign=1.
  - Misalign=0 in all other cases.
- ByteAddr is ignored in modes 0-3.
- Datapath is purely combinational into the stage registers. Latency is exactly 1 cycle from an accepted request (InValid&InReady) to OutValid with an empty pipe.
- Storage is two entries: main (drives outputs) and skid.
- InReady = !skid_valid, registered. It never depends combinationally on OutReady.
- Accept with main empty, or with main draining (OutReady=1): the data goes to main.
- Accept with main full and OutReady=0: the data goes to skid.
- Main drains (OutValid&OutReady) while skid is full: skid moves to main the same cycle. InReady rises the next cycle.
- No request is ever dropped or duplicated. Order is preserved.
- While OutValid=1 and OutReady=0, ExtOut and Misalign hold stable.
- InValid=0 with ExtMode/ExtIn toggling: no state change.
- Reset (synchronous):
  - OutValid=0, ExtOut=0, Misalign=0, skid cleared.
  - InReady=0 while Reset is high, 1 on the first cycle after.
  - Reset mid-stream discards both entries. No partial output follows.
- Simultaneous accept and drain with main full and skid empty: main is replaced by the new result. OutValid stays 1.

Decomposition:
- Shared package (core_pkg):
  - ext_mode_t enum (EXT_ZERO..EXT_LHU, 3 bits).
  - Constant UPPER_SHIFT=16.
- Sub-module ext_datapath: purely combinational mode/lane/sign logic, (ExtMode, ByteAddr, ExtIn) -> (result, misalign).
- The top level holds the two-entry elastic buffer and the handshake.

Test Plan:
- Immediate modes, OutReady=1, DATA_W=32, ExtIn[15:0]=16'h8004:
  - ZERO -> 32'h00008004.
  - SIGN -> 32'hFFFF8004.
  - UPPER -> 32'h80040000.
  - BRANCH -> 32'hFFFE0010.
  - Each result appears exactly 1 cycle after acceptance.
- Loads, ExtIn=32'h80FF7F01:
  - LB, ByteAddr=2 -> 32'hFFFFFFFF.
  - LBU, ByteAddr=3 -> 32'h00000080.
  - LH, ByteAddr=2 -> 32'hFFFF80FF.
  - LHU, ByteAddr=0 -> 32'h00007F01.
  - LH, ByteAddr=1 -> 32'h00007F01 with Misalign=1.
- Backpressure:
  - Hold OutReady=0 and send 3 requests (A, B, C): A is in main, B is in skid, InReady=0, C is held upstream.
  - Release OutReady: outputs appear in order A, B, C with no gaps once InReady recovers. ExtOut stays stable while stalled.
- Random valid/ready on both sides for 10k transactions: scoreboard matches in order, no loss or duplication, and InReady is never combinationally derived from OutReady.
- Reset asserted with both entries full: OutValid=0 the next cycle, InReady=1 the cycle after Reset falls, and no stale result is emitted.
- DATA_W=64 instance:
  - UPPER, imm 16'h8000 -> 64'hFFFFFFFF80000000.
  - LBU, ByteAddr=7, ExtIn[63:56]=8'hA5 -> 64'h00000000000000A5.
